// File: rtl/ps2_mouse_dev_if.sv
// Byte-level link between the PS/2 device PHY (master) and the mouse protocol engine (slave).
interface ps2_mouse_dev_if;
  logic       rx_strobe;
  logic [7:0] rx_byte;
  logic       tx_req;
  logic [7:0] tx_byte;
  logic       tx_ack;

  modport master (output rx_strobe, output rx_byte, output tx_ack, input tx_req, input tx_byte);
  modport slave  (input rx_strobe, input rx_byte, input tx_ack, output tx_req, output tx_byte);
endinterface

// File: rtl/ps2_mouse_dev.sv
// Device-side PS/2 mouse engine: movement accumulation, host command replies and
// 3-byte stream packets, one byte at a time through the PHY handshake.
module ps2_mouse_dev #(
  parameter int REPORT_DIV = 4096,
  parameter int ACC_W      = 10
) (
  input  logic              sysclk,
  input  logic              reset_n,
  input  logic              clk_en,
  input  logic              move_strobe,
  input  logic signed [8:0] dx,
  input  logic signed [8:0] dy,
  input  logic [2:0]        buttons,
  ps2_mouse_dev_if.slave    phy,
  output logic              enabled
);
  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

  localparam int DIV_W = $clog2(REPORT_DIV);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] REP_MAX = ACC_W'(255);
  localparam logic signed [ACC_W-1:0] REP_MIN = ACC_W'(-256);

  state_t                  state_reg, state_next;
  logic [7:0]              tx_byte_reg, tx_byte_next;
  logic [7:0]              q_reg [4];
  logic [7:0]              q_next [4];
  logic [2:0]              q_cnt_reg, q_cnt_next;
  logic                    enabled_reg, enabled_next;
  logic                    arg_wait_reg, arg_wait_next;
  logic                    boot_reg;
  logic [2:0]              btn_reg, btn_next;
  logic [DIV_W-1:0]        div_reg, div_next;
  logic signed [ACC_W-1:0] acc_reg [2];
  logic signed [ACC_W-1:0] acc_next [2];
  logic signed [8:0]       delta [2];
  logic                    ovr [2];
  logic [8:0]              rep [2];

  logic [7:0] resp [4];
  logic [2:0] resp_cnt;
  logic [7:0] src_q [4];
  logic [2:0] src_cnt;
  logic [7:0] pop_q [4];
  logic [7:0] pkt0, pkt1, pkt2;
  logic       cmd_clear, snap_cmd, pkt_fire, tick, acc_clear;

  function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [8:0] d);
    logic signed [ACC_W:0] s;
    s = $signed({a[ACC_W-1], a}) + $signed({{(ACC_W-8){d[8]}}, d});
    if (s[ACC_W] != s[ACC_W-1]) return s[ACC_W] ? ACC_MIN : ACC_MAX;
    return s[ACC_W-1:0];
  endfunction

  assign delta[0]  = dx;
  assign delta[1]  = dy;
  assign tick      = (div_reg == DIV_W'(REPORT_DIV - 1));
  assign div_next  = tick ? '0 : div_reg + 1'b1;
  assign acc_clear = cmd_clear | snap_cmd | pkt_fire;
  assign btn_next  = (snap_cmd | pkt_fire) ? buttons : btn_reg;

  // Per axis: clamp to the 9-bit packet range and fold in this cycle's move after any clear,
  // so a move landing on a snapshot cycle survives in the fresh accumulator.
  for (genvar gi = 0; gi < 2; gi++) begin : g_axis
    assign ovr[gi] = (acc_reg[gi] > REP_MAX) || (acc_reg[gi] < REP_MIN);
    assign rep[gi] = (acc_reg[gi] > REP_MAX) ? 9'h0FF :
                     (acc_reg[gi] < REP_MIN) ? 9'h100 : acc_reg[gi][8:0];
    assign acc_next[gi] = sat_add(acc_clear ? '0 : acc_reg[gi],
                                  move_strobe ? delta[gi] : 9'sd0);
  end

  assign pkt0 = {ovr[1], ovr[0], rep[1][8], rep[0][8], 1'b1, buttons};
  assign pkt1 = rep[0][7:0];
  assign pkt2 = rep[1][7:0];

  assign pkt_fire = boot_reg && tick && enabled_reg && (q_cnt_reg == 3'd0) &&
                    (state_reg == ST_IDLE) && !arg_wait_reg && !phy.rx_strobe &&
                    ((acc_reg[0] != '0) || (acc_reg[1] != '0) || (buttons != btn_reg));

  for (genvar gi = 0; gi < 3; gi++) begin : g_pop
    assign pop_q[gi] = src_q[gi+1];
  end
  assign pop_q[3] = 8'h00;

  // Command decode and selection of what the queue holds this cycle (a command replaces it).
  always_comb begin
    resp          = '{default: 8'h00};
    resp_cnt      = 3'd0;
    enabled_next  = enabled_reg;
    arg_wait_next = arg_wait_reg;
    cmd_clear     = 1'b0;
    snap_cmd      = 1'b0;
    if (phy.rx_strobe) begin
      resp[0]  = 8'hFA;
      resp_cnt = 3'd1;
      if (arg_wait_reg) begin
        arg_wait_next = 1'b0;
      end else begin
        case (phy.rx_byte)
          8'hFF: begin
            resp[1] = 8'hAA; resp[2] = 8'h00; resp_cnt = 3'd3;
            enabled_next = 1'b0; cmd_clear = 1'b1;
          end
          8'hF6, 8'hF5: begin enabled_next = 1'b0; cmd_clear = 1'b1; end
          8'hF4:        begin enabled_next = 1'b1; cmd_clear = 1'b1; end
          8'hF2:        begin resp[1] = 8'h00; resp_cnt = 3'd2; end
          8'hE8, 8'hF3: arg_wait_next = 1'b1;
          8'hEB: begin
            resp[1] = pkt0; resp[2] = pkt1; resp[3] = pkt2; resp_cnt = 3'd4;
            snap_cmd = 1'b1;
          end
          8'hE6, 8'hE7, 8'hEA, 8'hF0: ;
          default: resp[0] = 8'hFE;
        endcase
      end
    end

    if (phy.rx_strobe) begin
      src_q = resp; src_cnt = resp_cnt;
    end else if (!boot_reg) begin
      src_q = '{8'hAA, 8'h00, 8'h00, 8'h00}; src_cnt = 3'd2;
    end else if (pkt_fire) begin
      src_q = '{pkt0, pkt1, pkt2, 8'h00}; src_cnt = 3'd3;
    end else begin
      src_q = q_reg; src_cnt = q_cnt_reg;
    end
  end

  // Transmit FSM: the head byte is moved into tx_byte when sending starts, so a replacing
  // command only ever touches bytes that have not gone out yet.
  always_comb begin
    state_next   = state_reg;
    tx_byte_next = tx_byte_reg;
    q_next       = src_q;
    q_cnt_next   = src_cnt;
    case (state_reg)
      ST_SEND: if (phy.tx_ack) state_next = ST_GAP;
      default: begin
        if (src_cnt != 3'd0) begin
          tx_byte_next = src_q[0];
          q_next       = pop_q;
          q_cnt_next   = src_cnt - 3'd1;
          state_next   = ST_SEND;
        end else begin
          state_next = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      tx_byte_reg  <= 8'h00;
      q_cnt_reg    <= 3'd0;
      enabled_reg  <= 1'b0;
      arg_wait_reg <= 1'b0;
      boot_reg     <= 1'b0;
      btn_reg      <= 3'b000;
      div_reg      <= '0;
      for (int i = 0; i < 4; i++) q_reg[i] <= 8'h00;
      for (int i = 0; i < 2; i++) acc_reg[i] <= '0;
    end else if (clk_en) begin
      state_reg    <= state_next;
      tx_byte_reg  <= tx_byte_next;
      q_reg        <= q_next;
      q_cnt_reg    <= q_cnt_next;
      enabled_reg  <= enabled_next;
      arg_wait_reg <= arg_wait_next;
      boot_reg     <= 1'b1;
      btn_reg      <= btn_next;
      div_reg      <= div_next;
      acc_reg      <= acc_next;
    end
  end

  assign phy.tx_req  = (state_reg == ST_SEND);
  assign phy.tx_byte = tx_byte_reg;
  assign enabled     = enabled_reg;
endmodule

// File: tb/tb_ps2_mouse_dev.sv
// Scoreboard bench for ps2_mouse_dev: stimulus pushes expected tx bytes, a PHY-model
// monitor pops and compares each byte the device sends, then acks it.
module tb_ps2_mouse_dev;
  localparam int DIV       = 128;
  localparam int ACK_DELAY = 10;

  logic              sysclk = 1'b0;
  logic              reset_n = 1'b1;
  logic              clk_en = 1'b1;
  logic              move_strobe = 1'b0;
  logic signed [8:0] dx = '0;
  logic signed [8:0] dy = '0;
  logic [2:0]        buttons = 3'b000;
  logic              enabled;

  ps2_mouse_dev_if phy();

  ps2_mouse_dev #(.REPORT_DIV(DIV), .ACC_W(10)) dut (
    .sysclk(sysclk), .reset_n(reset_n), .clk_en(clk_en),
    .move_strobe(move_strobe), .dx(dx), .dy(dy), .buttons(buttons),
    .phy(phy), .enabled(enabled)
  );

  always #5 sysclk = ~sysclk;

  int         vectors = 0;
  int         miscompares = 0;
  int         sent_count = 0;
  int         cyc = 0;
  logic [7:0] exp_q [$];

  always @(posedge sysclk) if (reset_n) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic push(input logic [7:0] b);
    exp_q.push_back(b);
  endtask

  task automatic send_cmd(input logic [7:0] b);
    @(negedge sysclk);
    phy.rx_strobe = 1'b1;
    phy.rx_byte   = b;
    @(negedge sysclk);
    phy.rx_strobe = 1'b0;
  endtask

  task automatic move(input int x, input int y);
    @(negedge sysclk);
    move_strobe = 1'b1; dx = 9'(x); dy = 9'(y);
    @(negedge sysclk);
    move_strobe = 1'b0; dx = '0; dy = '0;
  endtask

  // Park stimulus half-way between report ticks so a tick never splits a move group.
  task automatic mid_window();
    while ((cyc % DIV) != DIV / 2) @(negedge sysclk);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || phy.tx_req) && n < 2000) begin
      @(negedge sysclk);
      n++;
    end
    vectors++;
    if (n >= 2000) begin
      miscompares++;
      $display("FAIL drain_%s: got %0d bytes outstanding, want 0", name, exp_q.size());
      exp_q.delete();
    end else begin
      $display("ok   drain_%s: all expected bytes sent", name);
    end
    cycles(4);
  endtask

  // PHY model: compare each requested byte, hold it ACK_DELAY cycles, ack, verify the gap.
  initial begin : monitor
    logic [7:0] want;
    logic       have;
    phy.tx_ack = 1'b0;
    forever begin
      @(negedge sysclk);
      if (reset_n && phy.tx_req) begin
        sent_count++;
        have = (exp_q.size() != 0);
        if (!have) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_byte: got %02h, want none", phy.tx_byte);
        end else begin
          want = exp_q.pop_front();
          check("tx_byte", 32'(phy.tx_byte), 32'(want));
        end
        cycles(ACK_DELAY - 1);
        if (have) check("tx_byte_held", 32'({phy.tx_req, phy.tx_byte}), 32'({1'b1, want}));
        phy.tx_ack = 1'b1;
        @(negedge sysclk);
        phy.tx_ack = 1'b0;
        check("gap_tx_req", 32'(phy.tx_req), 32'd0);
      end
    end
  end

  initial begin : stim
    int base;
    int n;
    phy.rx_strobe = 1'b0;
    phy.rx_byte   = 8'h00;
    #2 reset_n = 1'b0;
    cycles(3);
    check("rst_tx_req", 32'(phy.tx_req), 32'd0);
    check("rst_tx_byte", 32'(phy.tx_byte), 32'h00);
    check("rst_enabled", 32'(enabled), 32'd0);

    // 1: BAT reply after reset release, then silence
    push(8'hAA); push(8'h00);
    @(negedge sysclk) reset_n = 1'b1;
    drain("bat");
    cycles(20);
    check("idle_after_bat", 32'(phy.tx_req), 32'd0);

    // 2: enable, one move with left button
    push(8'hFA);
    send_cmd(8'hF4);
    drain("f4");
    check("enabled_f4", 32'(enabled), 32'd1);
    mid_window();
    push(8'h29); push(8'h05); push(8'hFD);
    buttons = 3'b001;
    move(5, -3);
    drain("pkt_move");

    // 3: saturating X sum, overflow flag, accumulator cleared afterwards
    mid_window();
    buttons = 3'b000;
    push(8'h48); push(8'hFF); push(8'h00);
    move(200, 0); move(200, 0); move(200, 0);
    drain("pkt_sat");
    cycles(2 * DIV);

    // 4: get ID, set rate with argument (second command replaces in-flight response), bad byte
    push(8'hFA); push(8'h00);
    send_cmd(8'hF2);
    drain("f2");
    push(8'hFA); push(8'hFA);
    send_cmd(8'hF3);
    cycles(2);
    send_cmd(8'h64);
    drain("f3_arg");
    push(8'hFE);
    send_cmd(8'h55);
    drain("bad_cmd");
    check("enabled_t4", 32'(enabled), 32'd1);

    // 5: reset command while packet byte1 is in flight drops byte2
    mid_window();
    base = sent_count;
    push(8'h08); push(8'h01);
    move(1, 0);
    n = 0;
    while (sent_count < base + 2 && n < 1000) begin
      @(negedge sysclk);
      n++;
    end
    check("byte1_started", 32'(sent_count >= base + 2), 32'd1);
    push(8'hFA); push(8'hAA); push(8'h00);
    send_cmd(8'hFF);
    drain("ff_mid_pkt");
    check("enabled_ff", 32'(enabled), 32'd0);

    // 6: read data while disabled, no stream packets afterwards
    move(7, 0);
    cycles(4);
    push(8'hFA); push(8'h08); push(8'h07); push(8'h00);
    send_cmd(8'hEB);
    drain("eb_x7");
    cycles(3 * DIV);

    // 7-9: negative saturation, exact +255 and +256 boundaries via read data
    move(0, -256); move(0, -256); move(0, -256);
    push(8'hFA); push(8'hA8); push(8'h00); push(8'h00);
    send_cmd(8'hEB);
    drain("eb_yneg_sat");
    move(255, 0);
    push(8'hFA); push(8'h08); push(8'hFF); push(8'h00);
    send_cmd(8'hEB);
    drain("eb_x255");
    move(255, 0); move(1, 0);
    push(8'hFA); push(8'h48); push(8'hFF); push(8'h00);
    send_cmd(8'hEB);
    drain("eb_x256");

    // 10: FF taken as a resolution argument, button-only packet, disable
    push(8'hFA);
    send_cmd(8'hE8);
    drain("e8");
    push(8'hFA);
    send_cmd(8'hFF);
    drain("e8_arg_ff");
    check("enabled_arg_ff", 32'(enabled), 32'd0);
    push(8'hFA);
    send_cmd(8'hF4);
    drain("f4_again");
    mid_window();
    push(8'h0C); push(8'h00); push(8'h00);
    buttons = 3'b100;
    drain("pkt_button");
    push(8'hFA);
    send_cmd(8'hF5);
    drain("f5");
    check("enabled_f5", 32'(enabled), 32'd0);
    cycles(DIV);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
